// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
//  Read port between the instruction fetch stage and instruction memory.
//  Only one read is outstanding at a time. The requester holds imem_req and
//  imem_addr steady until memory answers with a one-cycle imem_valid pulse.
//  imem_rdata is meaningful only while imem_valid is high.
//
//  Signals
//   imem_req    fetch -> mem   read request, held until imem_valid
//   imem_addr   fetch -> mem   word address (PC_W bits)
//   imem_rdata  mem -> fetch   instruction word (INSTR_W bits)
//   imem_valid  mem -> fetch   read data valid, single-cycle pulse
//
//  Modports
//   master  the fetch stage
//   slave   the instruction memory
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 9
);
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               imem_valid;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_valid
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_valid
   );
endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//  Non-pipelined instruction fetch stage. It requests one word from
//  instruction memory, latches the word and presents its fields to the
//  decoder, then moves the PC on: +1, or to a branch target. A HALT opcode
//  (4'b1110) parks the stage until reset.
//
//  Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   imem           instr_fetch_if.master (imem_req/addr/rdata/valid)
//   start          leave IDLE and begin fetching at the current PC
//   stall          downstream not ready; hold the issued instruction
//   branch_taken   redirect request, sampled only when an issue is accepted
//   branch_target  redirect destination
//   instr_valid    decoded fields and pc_out are valid
//   opcode/format/imm_flag/operand  fields of the latched word
//   pc_out         address of the issued instruction
//   halted         HALT retired; fetching has stopped
//   retire_cnt     (FETCH_RETIRE_CNT_EN only) saturating count of accepts
//
//  Configuration macro: FETCH_RETIRE_CNT_EN adds the retire_cnt output.
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int PC_W     = 8,
   parameter int INSTR_W  = 9,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   instr_fetch_if.master     imem,
   input  logic              start,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [PC_W-1:0]   branch_target,
   output logic              instr_valid,
   output logic [3:0]        opcode,
   output logic [1:0]        format,
   output logic              imm_flag,
   output logic [1:0]        operand,
   output logic [PC_W-1:0]   pc_out,
   output logic              halted
`ifdef FETCH_RETIRE_CNT_EN
   ,
   output logic [15:0]       retire_cnt
`endif
);

   localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
   localparam logic [3:0]      OP_HALT    = 4'b1110;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      ISSUE,
      HALTED
   } state_t;

   state_t             state_reg,  state_next;
   logic [PC_W-1:0]    pc_reg,     pc_next;
   logic [PC_W-1:0]    pc_out_reg, pc_out_next;
   logic [INSTR_W-1:0] instr_reg,  instr_next;
   logic               accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         pc_reg     <= RESET_PC_V;
         pc_out_reg <= RESET_PC_V;
         instr_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         pc_out_reg <= pc_out_next;
         instr_reg  <= instr_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      pc_out_next = pc_out_reg;
      instr_next  = instr_reg;
      accept      = 1'b0;
      imem.imem_req = 1'b0;
      instr_valid = 1'b0;
      halted      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) state_next = FETCH;
         end
         FETCH: begin
            imem.imem_req = 1'b1;
            if (imem.imem_valid) begin
               instr_next  = imem.imem_rdata;
               pc_out_next = pc_reg;
               state_next  = ISSUE;
            end
         end
         ISSUE: begin
            instr_valid = 1'b1;
            // Under stall nothing moves, so branch_taken has no effect here.
            if (!stall) begin
               accept = 1'b1;
               if (instr_reg[8:5] == OP_HALT) begin
                  // HALT wins over a simultaneous branch and keeps the PC.
                  state_next = HALTED;
               end else if (branch_taken) begin
                  pc_next    = branch_target;
                  state_next = FETCH;
               end else begin
                  pc_next    = pc_reg + 1'b1;   // wraps at 2^PC_W
                  state_next = FETCH;
               end
            end
         end
         HALTED: begin
            halted = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   assign imem.imem_addr = pc_reg;
   assign opcode         = instr_reg[8:5];
   assign format         = instr_reg[4:3];
   assign imm_flag       = instr_reg[2];
   assign operand        = instr_reg[1:0];
   assign pc_out         = pc_out_reg;

`ifdef FETCH_RETIRE_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_cnt <= '0;
      end else if (accept && (retire_cnt != 16'hFFFF)) begin
         retire_cnt <= retire_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//  Directed bench for instr_fetch. Inputs change just after a falling edge.
//  Outputs are sampled on falling edges, so every check sits half a cycle away
//  from the rising edge that updates the DUT. The memory side is driven
//  directly by the tasks.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 9;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            stall = 1'b0;
   logic            branch_taken = 1'b0;
   logic [PC_W-1:0] branch_target = '0;
   logic            instr_valid;
   logic [3:0]      opcode;
   logic [1:0]      format;
   logic            imm_flag;
   logic [1:0]      operand;
   logic [PC_W-1:0] pc_out;
   logic            halted;
`ifdef FETCH_RETIRE_CNT_EN
   logic [15:0]     retire_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) imem_bus ();

   instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem          (imem_bus.master),
      .start         (start),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instr_valid   (instr_valid),
      .opcode        (opcode),
      .format        (format),
      .imm_flag      (imm_flag),
      .operand       (operand),
      .pc_out        (pc_out),
      .halted        (halted)
`ifdef FETCH_RETIRE_CNT_EN
      ,
      .retire_cnt    (retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      imem_bus.imem_valid = 1'b0;
      imem_bus.imem_rdata = '0;
   end

   // Test 1: reset values, then two single-cycle fetches at 2 cycles/instr
   task automatic test_reset_and_basic();
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({imem_bus.imem_req, instr_valid, halted, pc_out, opcode, format, imm_flag, operand}
          !== {1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 2'b0, 1'b0, 2'b0}) begin
         failures++;
         $display("FAIL reset_state: req=%b iv=%b halt=%b pc_out=%h op=%h required all zero",
                  imem_bus.imem_req, instr_valid, halted, pc_out, opcode);
      end
      rst_n = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({imem_bus.imem_req, imem_bus.imem_addr, instr_valid} !== {1'b1, 8'h00, 1'b0}) begin
         failures++;
         $display("FAIL fetch0: req=%b addr=%h iv=%b required req=1 addr=00 iv=0",
                  imem_bus.imem_req, imem_bus.imem_addr, instr_valid);
      end
      imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = 9'h0E0;
      @(negedge clk);
      imem_bus.imem_valid = 1'b0;
      checks++;
      if ({instr_valid, imem_bus.imem_req, opcode, pc_out} !== {1'b1, 1'b0, 4'h7, 8'h00}) begin
         failures++;
         $display("FAIL issue_add: iv=%b req=%b op=%h pc_out=%h required iv=1 req=0 op=7 pc_out=00",
                  instr_valid, imem_bus.imem_req, opcode, pc_out);
      end
      @(negedge clk);
      checks++;
      if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 8'h01}) begin
         failures++;
         $display("FAIL fetch1: req=%b addr=%h required req=1 addr=01",
                  imem_bus.imem_req, imem_bus.imem_addr);
      end
      imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = 9'h100;
      @(negedge clk);
      imem_bus.imem_valid = 1'b0;
      checks++;
      if ({instr_valid, opcode, pc_out} !== {1'b1, 4'h8, 8'h01}) begin
         failures++;
         $display("FAIL issue_sub: iv=%b op=%h pc_out=%h required iv=1 op=8 pc_out=01",
                  instr_valid, opcode, pc_out);
      end
      @(negedge clk);   // accepted -> FETCH at pc=2
   endtask

   // Test 2: branch to 5, then memory answers on the third FETCH cycle
   task automatic test_latency();
      imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = 9'h000;
      @(negedge clk);
      imem_bus.imem_valid = 1'b0;
      branch_taken = 1'b1; branch_target = 8'h05;
      @(negedge clk);
      branch_taken = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({imem_bus.imem_req, imem_bus.imem_addr, instr_valid} !== {1'b1, 8'h05, 1'b0}) begin
            failures++;
            $display("FAIL latency_cycle%0d: req=%b addr=%h iv=%b required req=1 addr=05 iv=0",
                     i, imem_bus.imem_req, imem_bus.imem_addr, instr_valid);
         end
         if (i == 2) begin
            imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = 9'h0A5;
         end
         @(negedge clk);
      end
      imem_bus.imem_valid = 1'b0;
      checks++;
      if ({instr_valid, imem_bus.imem_req, pc_out, opcode, format, imm_flag, operand}
          !== {1'b1, 1'b0, 8'h05, 4'h5, 2'b00, 1'b1, 2'b01}) begin
         failures++;
         $display("FAIL latency_issue: iv=%b req=%b pc_out=%h op=%h fmt=%b imm=%b opd=%b required 1 0 05 5 00 1 01",
                  instr_valid, imem_bus.imem_req, pc_out, opcode, format, imm_flag, operand);
      end
   endtask

   // Test 3: stall for 4 cycles with branch_taken asserted; no redirect
   task automatic test_stall();
      stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h33;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({instr_valid, imem_bus.imem_req, pc_out, opcode, operand} !== {1'b1, 1'b0, 8'h05, 4'h5, 2'b01}) begin
            failures++;
            $display("FAIL stall_hold%0d: iv=%b req=%b pc_out=%h op=%h opd=%b required 1 0 05 5 01",
                     i, instr_valid, imem_bus.imem_req, pc_out, opcode, operand);
         end
      end
      stall = 1'b0; branch_taken = 1'b0;
      @(negedge clk);
      checks++;
      if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 8'h06}) begin
         failures++;
         $display("FAIL stall_release: req=%b addr=%h required req=1 addr=06",
                  imem_bus.imem_req, imem_bus.imem_addr);
      end
   endtask

   // Test 4: accepted branch to 0x40
   task automatic test_branch();
      imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = 9'h020;
      @(negedge clk);
      imem_bus.imem_valid = 1'b0;
      branch_taken = 1'b1; branch_target = 8'h40;
      @(negedge clk);
      branch_taken = 1'b0;
      checks++;
      if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 8'h40}) begin
         failures++;
         $display("FAIL branch_addr: req=%b addr=%h required req=1 addr=40",
                  imem_bus.imem_req, imem_bus.imem_addr);
      end
      imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = 9'h060;
      @(negedge clk);
      imem_bus.imem_valid = 1'b0;
      checks++;
      if ({instr_valid, pc_out, opcode} !== {1'b1, 8'h40, 4'h3}) begin
         failures++;
         $display("FAIL branch_issue: iv=%b pc_out=%h op=%h required iv=1 pc_out=40 op=3",
                  instr_valid, pc_out, opcode);
      end
   endtask

   // Test 5: branch to 0xFF, then a plain accept wraps the PC to 0x00
   task automatic test_wrap();
      branch_taken = 1'b1; branch_target = 8'hFF;
      @(negedge clk);
      branch_taken = 1'b0;
      imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = 9'h020;
      @(negedge clk);
      imem_bus.imem_valid = 1'b0;
      checks++;
      if ({instr_valid, pc_out} !== {1'b1, 8'hFF}) begin
         failures++;
         $display("FAIL wrap_issue: iv=%b pc_out=%h required iv=1 pc_out=ff", instr_valid, pc_out);
      end
      @(negedge clk);
      checks++;
      if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 8'h00}) begin
         failures++;
         $display("FAIL wrap_addr: req=%b addr=%h required req=1 addr=00",
                  imem_bus.imem_req, imem_bus.imem_addr);
      end
   endtask

   // Test 6: HALT wins over branch_taken; start is ignored; reset clears it
   task automatic test_halt();
      imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = 9'h1C0;
      @(negedge clk);
      imem_bus.imem_valid = 1'b0;
      checks++;
      if ({instr_valid, opcode} !== {1'b1, 4'hE}) begin
         failures++;
         $display("FAIL halt_issue: iv=%b op=%h required iv=1 op=e", instr_valid, opcode);
      end
      branch_taken = 1'b1; branch_target = 8'h77;
      @(negedge clk);
      branch_taken = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({halted, imem_bus.imem_req, instr_valid, imem_bus.imem_addr} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL halted%0d: halt=%b req=%b iv=%b addr=%h required 1 0 0 00",
                     i, halted, imem_bus.imem_req, instr_valid, imem_bus.imem_addr);
         end
         @(negedge clk);
      end
      start = 1'b0;
`ifdef FETCH_RETIRE_CNT_EN
      checks++;
      if (retire_cnt !== 16'd8) begin
         failures++;
         $display("FAIL retire_cnt: got %0d required 8", retire_cnt);
      end
`endif
      rst_n = 1'b0;
      #1;
      checks++;
      if ({halted, imem_bus.imem_req, instr_valid} !== 3'b000) begin
         failures++;
         $display("FAIL halt_reset: halt=%b req=%b iv=%b required 000",
                  halted, imem_bus.imem_req, instr_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Test 7: reset during FETCH, then a late imem_valid is dropped
   task automatic test_reset_mid_fetch();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (imem_bus.imem_req !== 1'b1) begin
         failures++;
         $display("FAIL midfetch_req: req=%b required 1", imem_bus.imem_req);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (imem_bus.imem_req !== 1'b0) begin
         failures++;
         $display("FAIL midfetch_reset: req=%b required 0", imem_bus.imem_req);
      end
      @(negedge clk);
      rst_n = 1'b1;
      imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = 9'h0E0;
      @(negedge clk);
      imem_bus.imem_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({instr_valid, imem_bus.imem_req, halted, opcode, pc_out} !== {1'b0, 1'b0, 1'b0, 4'h0, 8'h00}) begin
            failures++;
            $display("FAIL late_valid%0d: iv=%b req=%b halt=%b op=%h pc_out=%h required 0 0 0 0 00",
                     i, instr_valid, imem_bus.imem_req, halted, opcode, pc_out);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset_and_basic();
      test_latency();
      test_stall();
      test_branch();
      test_wrap();
      test_halt();
      test_reset_mid_fetch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
